// File: rtl/burst_rr_scheduler_if.sv
// Bundle of user TX ports, shared TX channel and credit-return channel for the burst scheduler.
// The scheduler connects through the slave view; the users and shell side connect through the master view.
interface burst_rr_scheduler_if #(
    parameter int NUMBER_OF_USERS = 4,
    parameter int USERS_BITS      = 2,
    parameter int USER_LINE_WIDTH = 512
);
    logic [USER_LINE_WIDTH-1:0] usr_tx_lines [NUMBER_OF_USERS];
    logic [NUMBER_OF_USERS-1:0] usr_tx_last;
    logic [NUMBER_OF_USERS-1:0] usr_tx_valid;
    logic [NUMBER_OF_USERS-1:0] usr_tx_ready;
    logic [USER_LINE_WIDTH-1:0] arb_tx_line;
    logic [USERS_BITS-1:0]      arb_tx_tag;
    logic                       arb_tx_last;
    logic                       arb_tx_valid;
    logic                       arb_tx_ready;
    logic                       rsp_valid;
    logic [USERS_BITS-1:0]      rsp_tag;
    logic                       credit_err;

    modport slave (
        input  usr_tx_lines, usr_tx_last, usr_tx_valid, arb_tx_ready, rsp_valid, rsp_tag,
        output usr_tx_ready, arb_tx_line, arb_tx_tag, arb_tx_last, arb_tx_valid, credit_err
    );

    modport master (
        output usr_tx_lines, usr_tx_last, usr_tx_valid, arb_tx_ready, rsp_valid, rsp_tag,
        input  usr_tx_ready, arb_tx_line, arb_tx_tag, arb_tx_last, arb_tx_valid, credit_err
    );
endinterface

// File: rtl/burst_rr_scheduler.sv
// Burst-granular round-robin scheduler: one grant per burst, held until the last line is accepted,
// with per-user credit counters bounding outstanding lines and a sticky error on bad credit returns.
module burst_rr_scheduler #(
    parameter int NUMBER_OF_USERS = 4,
    parameter int USERS_BITS      = 2,
    parameter int USER_LINE_WIDTH = 512,
    parameter int MAX_CREDITS     = 16,
    parameter int CREDIT_BITS     = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    burst_rr_scheduler_if.slave bus
);
    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = CREDIT_BITS'(MAX_CREDITS);

    state_t                     state_q, state_d;
    logic [USERS_BITS-1:0]      ptr_q, ptr_d;
    logic [USERS_BITS-1:0]      grant_q, grant_d;
    logic [CREDIT_BITS-1:0]     credit_q [NUMBER_OF_USERS];
    logic [CREDIT_BITS-1:0]     credit_d [NUMBER_OF_USERS];
    logic [NUMBER_OF_USERS-1:0] credit_ovf;
    logic                       credit_err_q;
    logic [NUMBER_OF_USERS-1:0] eligible;
    logic [USERS_BITS-1:0]      pick;
    logic                       pick_found;
    logic                       grant_has_credit;
    logic                       xfer;
    logic                       tag_illegal;

    // Saturating credit update: returns {overflow, next_count}. A simultaneous take and
    // return cancel out, so a full counter that also transfers is not an overflow.
    function automatic logic [CREDIT_BITS:0] credit_update(
        input logic [CREDIT_BITS-1:0] cur,
        input logic                   dec,
        input logic                   inc
    );
        if (inc && !dec) begin
            if (cur == CREDIT_MAX) return {1'b1, cur};
            return {1'b0, cur + 1'b1};
        end
        if (dec && !inc) return {1'b0, cur - 1'b1};
        return {1'b0, cur};
    endfunction

    always_comb begin
        for (int i = 0; i < NUMBER_OF_USERS; i++) begin
            eligible[i] = bus.usr_tx_valid[i] && (credit_q[i] != '0);
        end
    end

    // First eligible user scanning upward from ptr, wrapping at NUMBER_OF_USERS.
    always_comb begin
        int                    idx;
        logic [USERS_BITS-1:0] cand;
        pick       = ptr_q;
        pick_found = 1'b0;
        idx        = 0;
        cand       = '0;
        for (int k = 0; k < NUMBER_OF_USERS; k++) begin
            idx  = (32'(ptr_q) + k) % NUMBER_OF_USERS;
            cand = USERS_BITS'(idx);
            if (!pick_found && eligible[cand]) begin
                pick_found = 1'b1;
                pick       = cand;
            end
        end
    end

    assign grant_has_credit = (credit_q[grant_q] != '0);
    assign xfer             = bus.arb_tx_valid && bus.arb_tx_ready;
    assign tag_illegal      = (32'(bus.rsp_tag) >= NUMBER_OF_USERS);

    always_comb begin
        bus.arb_tx_line  = bus.usr_tx_lines[grant_q];
        bus.arb_tx_tag   = grant_q;
        bus.arb_tx_last  = bus.usr_tx_last[grant_q];
        bus.arb_tx_valid = 1'b0;
        bus.usr_tx_ready = '0;
        if (state_q == BURST) begin
            bus.arb_tx_valid          = bus.usr_tx_valid[grant_q] && grant_has_credit;
            bus.usr_tx_ready[grant_q] = bus.arb_tx_ready && grant_has_credit;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (xfer && bus.arb_tx_last) begin
                    ptr_d   = (32'(grant_q) == NUMBER_OF_USERS - 1) ? '0 : grant_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        logic [CREDIT_BITS:0] res;
        res = '0;
        for (int i = 0; i < NUMBER_OF_USERS; i++) begin
            res = credit_update(credit_q[i],
                                xfer && (32'(grant_q) == i),
                                bus.rsp_valid && !tag_illegal && (32'(bus.rsp_tag) == i));
            credit_ovf[i] = res[CREDIT_BITS];
            credit_d[i]   = res[CREDIT_BITS-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            grant_q      <= '0;
            credit_err_q <= 1'b0;
            for (int i = 0; i < NUMBER_OF_USERS; i++) credit_q[i] <= CREDIT_MAX;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            credit_err_q <= credit_err_q | (bus.rsp_valid && tag_illegal) | (|credit_ovf);
            for (int i = 0; i < NUMBER_OF_USERS; i++) credit_q[i] <= credit_d[i];
        end
    end

    assign bus.credit_err = credit_err_q;
endmodule

// File: tb/tb_burst_rr_scheduler.sv
// Directed bench for burst_rr_scheduler: user beat queues drive the ports, a scoreboard of
// expected {last, tag, line} entries is checked on every shared-channel transfer.
module tb_burst_rr_scheduler;
    localparam int N  = 4;
    localparam int UB = 2;
    localparam int LW = 512;
    localparam int MC = 16;
    localparam int CB = 5;

    typedef logic [LW-1:0] wide_t;
    typedef struct packed { logic last; wide_t line; } beat_t;
    typedef struct packed { logic last; logic [UB-1:0] tag; wide_t line; } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    burst_rr_scheduler_if #(.NUMBER_OF_USERS(N), .USERS_BITS(UB), .USER_LINE_WIDTH(LW)) bus ();

    burst_rr_scheduler #(
        .NUMBER_OF_USERS(N), .USERS_BITS(UB), .USER_LINE_WIDTH(LW),
        .MAX_CREDITS(MC), .CREDIT_BITS(CB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int          total = 0;
    int          bad = 0;
    int          xfer_cnt = 0;
    int          cyc = 0;
    int          seq = 0;
    int          xcyc[$];
    exp_t        sb[$];
    beat_t       uq [N][$];
    logic [N-1:0] last_rdy;

    task automatic chk(input string tag, input wide_t obs, input wide_t exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic wide_t mk_line(input int u, input int s);
        return (wide_t'(u + 1) << 480) | (wide_t'(s) << 8) | wide_t'(8'h5A);
    endfunction

    task automatic add_burst(input int u, input int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.last = (k == n - 1);
            b.line = mk_line(u, seq);
            seq++;
            uq[u].push_back(b);
            sb.push_back('{last: b.last, tag: UB'(u), line: b.line});
        end
    endtask

    task automatic drive();
        for (int u = 0; u < N; u++) begin
            if (uq[u].size() != 0) begin
                bus.usr_tx_valid[u] = 1'b1;
                bus.usr_tx_last[u]  = uq[u][0].last;
                bus.usr_tx_lines[u] = uq[u][0].line;
            end else begin
                bus.usr_tx_valid[u] = 1'b0;
                bus.usr_tx_last[u]  = 1'b0;
                bus.usr_tx_lines[u] = '0;
            end
        end
    endtask

    task automatic check_xfer();
        exp_t e;
        xfer_cnt++;
        xcyc.push_back(cyc);
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL sb_underflow observed=tag%0d expected=no_transfer", bus.arb_tx_tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("xfer_tag", wide_t'(bus.arb_tx_tag), wide_t'(e.tag));
            chk("xfer_line", bus.arb_tx_line, e.line);
            chk("xfer_last", wide_t'(bus.arb_tx_last), wide_t'(e.last));
        end
    endtask

    // One clock: observe at the falling edge, then advance user queues after the rising edge.
    task automatic tick();
        @(negedge clk);
        last_rdy = bus.usr_tx_ready;
        if (bus.arb_tx_valid && bus.arb_tx_ready) check_xfer();
        @(posedge clk);
        #1;
        cyc++;
        for (int u = 0; u < N; u++) begin
            if (last_rdy[u] && uq[u].size() != 0) void'(uq[u].pop_front());
        end
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.arb_tx_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_tag = '0;
        for (int u = 0; u < N; u++) uq[u].delete();
        sb.delete();
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", wide_t'(bus.arb_tx_valid), wide_t'(0));
        chk("rst_ready", wide_t'(bus.usr_tx_ready), wide_t'(0));
        chk("rst_tag", wide_t'(bus.arb_tx_tag), wide_t'(0));
        chk("rst_err", wide_t'(bus.credit_err), wide_t'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        xfer_cnt = 0;
        cyc = 0;
        xcyc.delete();
    endtask

    initial begin
        // Round robin over single-line bursts.
        do_reset();
        bus.arb_tx_ready = 1'b1;
        for (int r = 0; r < 2; r++) for (int u = 0; u < N; u++) add_burst(u, 1);
        drive();
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        chk("rr_drain", wide_t'(sb.size()), wide_t'(0));
        for (int i = 0; i < 7; i++) chk("rr_gap", wide_t'(xcyc[i+1] - xcyc[i]), wide_t'(2));

        // Burst lock: user 1's 4-line burst excludes user 2.
        do_reset();
        bus.arb_tx_ready = 1'b1;
        add_burst(1, 4);
        add_burst(2, 1);
        drive();
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            tick();
            if (xfer_cnt < 4) chk("lock_rdy2", wide_t'(last_rdy[2]), wide_t'(0));
        end
        chk("lock_drain", wide_t'(sb.size()), wide_t'(0));
        chk("lock_stream", wide_t'(xcyc[3] - xcyc[0]), wide_t'(3));
        chk("lock_bubble", wide_t'(xcyc[4] - xcyc[3]), wide_t'(2));

        // Credit exhaustion and one-line-per-return recovery.
        do_reset();
        bus.arb_tx_ready = 1'b1;
        add_burst(0, 20);
        drive();
        repeat (30) tick();
        chk("exh_count", wide_t'(xfer_cnt), wide_t'(MC));
        chk("exh_valid", wide_t'(bus.arb_tx_valid), wide_t'(0));
        for (int k = 0; k < 3; k++) begin
            bus.rsp_valid = 1'b1;
            bus.rsp_tag = 2'd0;
            tick();
            bus.rsp_valid = 1'b0;
            chk("exh_hold", wide_t'(xfer_cnt), wide_t'(MC + k));
            tick();
            chk("exh_ret", wide_t'(xfer_cnt), wide_t'(MC + k + 1));
        end
        chk("exh_left", wide_t'(sb.size()), wide_t'(1));
        chk("exh_err", wide_t'(bus.credit_err), wide_t'(0));

        // Transfer and return for the same user in the same cycle, then overflow.
        do_reset();
        bus.arb_tx_ready = 1'b1;
        add_burst(3, 20);
        drive();
        tick();
        bus.rsp_valid = 1'b1;
        bus.rsp_tag = 2'd3;
        repeat (4) tick();
        bus.rsp_valid = 1'b0;
        chk("sim_xfer", wide_t'(xfer_cnt), wide_t'(4));
        chk("sim_err", wide_t'(bus.credit_err), wide_t'(0));
        for (int i = 0; i < 30 && sb.size() != 0; i++) tick();
        chk("sim_all", wide_t'(xfer_cnt), wide_t'(20));
        chk("sim_err2", wide_t'(bus.credit_err), wide_t'(0));
        bus.rsp_valid = 1'b1;
        bus.rsp_tag = 2'd2;
        tick();
        bus.rsp_valid = 1'b0;
        chk("ovf_err", wide_t'(bus.credit_err), wide_t'(1));
        repeat (3) tick();
        chk("ovf_sticky", wide_t'(bus.credit_err), wide_t'(1));

        // Back-pressure mid-burst, then asynchronous reset mid-burst.
        do_reset();
        bus.arb_tx_ready = 1'b1;
        add_burst(1, 1);
        add_burst(2, 4);
        drive();
        for (int i = 0; i < 20 && xfer_cnt < 3; i++) tick();
        chk("bp_pre", wide_t'(xfer_cnt), wide_t'(3));
        bus.arb_tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", wide_t'(bus.arb_tx_valid), wide_t'(1));
            chk("bp_tag", wide_t'(bus.arb_tx_tag), wide_t'(2));
            chk("bp_line", bus.arb_tx_line, sb[0].line);
        end
        chk("bp_count", wide_t'(xfer_cnt), wide_t'(3));
        bus.arb_tx_ready = 1'b1;
        tick();
        chk("bp_resume", wide_t'(xfer_cnt), wide_t'(4));
        rst_n = 1'b0;
        #2;
        chk("arst_valid", wide_t'(bus.arb_tx_valid), wide_t'(0));
        chk("arst_ready", wide_t'(bus.usr_tx_ready), wide_t'(0));
        do_reset();
        bus.arb_tx_ready = 1'b1;
        add_burst(0, 1);
        add_burst(2, 17);
        drive();
        for (int i = 0; i < 40 && sb.size() > 1; i++) tick();
        repeat (3) tick();
        chk("arst_credits", wide_t'(xfer_cnt), wide_t'(1 + MC));
        chk("arst_left", wide_t'(sb.size()), wide_t'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
